// File: rtl/cache_arbiter.sv
// Two-client physical-memory arbiter: an I-cache and a D-cache share one memory port.
// Ties alternate through last_grant, and every transaction ends with a one-cycle RELEASE.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_next;
    logic   last_grant, last_grant_next;
    logic   i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Read data fans out to both clients; only the resp strobes qualify it.
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        i_pmem_resp     = 1'b0;
        d_pmem_resp     = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the side that did not win last time is granted.
                if (i_req && d_req) begin
                    if (last_grant) begin
                        state_next      = SERVE_I;
                        last_grant_next = 1'b0;
                    end else begin
                        state_next      = SERVE_D;
                        last_grant_next = 1'b1;
                    end
                end else if (i_req) begin
                    state_next      = SERVE_I;
                    last_grant_next = 1'b0;
                end else if (d_req) begin
                    state_next      = SERVE_D;
                    last_grant_next = 1'b1;
                end
            end
            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_pmem_address;
                i_pmem_resp = mem_resp;
                if (mem_resp) begin
                    state_next = RELEASE;
                end
            end
            SERVE_D: begin
                // Write-back wins when the D-cache raises both read and write.
                mem_write   = d_pmem_write;
                mem_read    = ~d_pmem_write;
                mem_address = d_pmem_address;
                mem_wdata   = d_pmem_wdata;
                d_pmem_resp = mem_resp;
                if (mem_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter: single-side reads/writes, tie alternation,
// back-to-back spacing, dropped requests and asynchronous reset mid-transaction.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk),
        .rst(rst),
        .i_pmem_read(i_pmem_read),
        .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata),
        .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address),
        .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata),
        .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0DEF;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = 32'h0000_0ABC;
        d_pmem_wdata = {LW{1'b1}};
        mem_rdata = '0;
        mem_resp = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++;
            $display("FAIL reset_cmd got %b want 00", {mem_read, mem_write});
        end
        checks++;
        if (mem_address !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_addr_data got %h/%h want 0", mem_address, mem_wdata[31:0]);
        end
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL reset_resp got %b want 00", {i_pmem_resp, d_pmem_resp});
        end
        i_pmem_read = 1'b0;
        mem_resp = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want 0", mem_read);
        end
    endtask

    task automatic test_i_read();
        logic [LW-1:0] line;
        line = {8{32'hC0DE_0060}};
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0060;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL i_read_latency got %b want 0", mem_read);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            mem_resp = (c == 5);
            mem_rdata = (c == 5) ? line : '0;
            #1;
            checks++;
            if ({mem_read, mem_write} !== 2'b10 || mem_address !== 32'h0000_0060 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL i_read_cmd c%0d got r%b w%b a%h want r1 w0 a00000060", c, mem_read, mem_write, mem_address);
            end
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== {(c == 5), 1'b0}) begin
                errors++;
                $display("FAIL i_read_resp c%0d got %b want %b", c, {i_pmem_resp, d_pmem_resp}, {(c == 5), 1'b0});
            end
        end
        checks++;
        if (i_pmem_rdata !== line) begin
            errors++;
            $display("FAIL i_read_rdata got %h want %h", i_pmem_rdata[31:0], line[31:0]);
        end
        tick();
        i_pmem_read = 1'b0;
        #1;
        // mem_resp still high here: RELEASE must not forward it.
        checks++;
        if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL i_read_release got %b want 0000", {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
        end
        tick();
        mem_resp = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++;
            $display("FAIL i_read_idle got %b want 00", {mem_read, mem_write});
        end
    endtask

    task automatic test_d_write(input logic rd_too, input logic [AW-1:0] addr, input int lat);
        logic [LW-1:0] wd;
        wd = {(LW/8){8'hA5}};
        tick();
        d_pmem_write = 1'b1;
        d_pmem_read = rd_too;
        d_pmem_address = addr;
        d_pmem_wdata = wd;
        for (int c = 1; c <= lat; c++) begin
            tick();
            mem_resp = (c == lat);
            #1;
            checks++;
            if ({mem_read, mem_write} !== 2'b01 || mem_address !== addr || mem_wdata !== wd) begin
                errors++;
                $display("FAIL d_write_cmd c%0d got r%b w%b a%h want r0 w1 a%h", c, mem_read, mem_write, mem_address, addr);
            end
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== {1'b0, (c == lat)}) begin
                errors++;
                $display("FAIL d_write_resp c%0d got %b want %b", c, {i_pmem_resp, d_pmem_resp}, {1'b0, (c == lat)});
            end
        end
        tick();
        mem_resp = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, d_pmem_resp} !== 3'b000) begin
            errors++;
            $display("FAIL d_write_release got %b want 000", {mem_read, mem_write, d_pmem_resp});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_rd;
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0080;
        for (int c = 1; c <= 7; c++) begin
            exp_rd = (c % 3 == 1);
            tick();
            mem_resp = exp_rd;
            if (c == 7) i_pmem_read = 1'b0;
            #1;
            checks++;
            if (mem_read !== exp_rd || i_pmem_resp !== exp_rd) begin
                errors++;
                $display("FAIL b2b c%0d got rd%b resp%b want %b", c, mem_read, i_pmem_resp, exp_rd);
            end
        end
        tick();
        mem_resp = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        logic          serve;
        logic          exp_d;
        logic [AW-1:0] exp_a;
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0200;
        for (int c = 1; c <= 12; c++) begin
            serve = (c % 3 == 1);
            exp_d = (c == 1 || c == 7);
            exp_a = !serve ? 32'h0 : (exp_d ? 32'h0000_0200 : 32'h0000_0100);
            tick();
            mem_resp = serve;
            if (c == 11) begin
                i_pmem_read = 1'b0;
                d_pmem_read = 1'b0;
            end
            #1;
            checks++;
            if (mem_read !== serve || mem_address !== exp_a) begin
                errors++;
                $display("FAIL tie_cmd c%0d got rd%b a%h want rd%b a%h", c, mem_read, mem_address, serve, exp_a);
            end
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== {serve & ~exp_d, serve & exp_d}) begin
                errors++;
                $display("FAIL tie_resp c%0d got %b want %b", c, {i_pmem_resp, d_pmem_resp}, {serve & ~exp_d, serve & exp_d});
            end
        end
        mem_resp = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0300;
        tick();
        tick();
        #1;
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_0300) begin
            errors++;
            $display("FAIL rst_mid_pre got rd%b a%h want rd1 a00000300", mem_read, mem_address);
        end
        rst = 1'b1;
        i_pmem_read = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00 || mem_address !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got rd%b a%h want rd0 a0", mem_read, mem_address);
        end
        #1;
        rst = 1'b0;
        tick();
        mem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp, mem_read} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_late_resp got %b want 000", {i_pmem_resp, d_pmem_resp, mem_read});
        end
        tick();
        mem_resp = 1'b0;
        #1;
        checks++;
        if ({mem_read, i_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_idle got %b want 00", {mem_read, i_pmem_resp});
        end
    endtask

    task automatic test_drop();
        logic exp_rd;
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0400;
        for (int c = 1; c <= 7; c++) begin
            exp_rd = (c <= 4);
            tick();
            if (c == 2) i_pmem_read = 1'b0;
            mem_resp = (c == 4);
            #1;
            checks++;
            if (mem_read !== exp_rd || i_pmem_resp !== (c == 4)) begin
                errors++;
                $display("FAIL drop c%0d got rd%b resp%b want rd%b resp%b", c, mem_read, i_pmem_resp, exp_rd, (c == 4));
            end
        end
        mem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write(1'b0, 32'h0000_1000, 3);
        test_d_write(1'b1, 32'h0000_2000, 2);
        test_back_to_back();
        test_tie();
        test_reset_mid();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter LINE_W, default 256, meaning cache-line data width of all ports.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_pmem_read  input  1  I-cache line-fill request.
REQ-006 SHALL have port i_pmem_address  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_pmem_rdata  output  LINE_W  line data to I-cache.
REQ-008 SHALL have port i_pmem_resp  output  1  I-cache transaction complete.
REQ-009 SHALL have port d_pmem_read  input  1  D-cache line-fill request.
REQ-010 SHALL have port d_pmem_write  input  1  D-cache write-back request.
REQ-011 SHALL have port d_pmem_address  input  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_pmem_wdata  input  LINE_W  D-cache write-back data.
REQ-013 SHALL have port d_pmem_rdata  output  LINE_W  line data to D-cache.
REQ-014 SHALL have port d_pmem_resp  output  1  D-cache transaction complete.
REQ-015 SHALL have ports mem_read, mem_write  output  1 each  physical-memory command.
REQ-016 SHALL have port mem_address  output  ADDR_W  physical-memory address.
REQ-017 SHALL have port mem_wdata  output  LINE_W  physical-memory write data.
REQ-018 SHALL have ports mem_rdata  input  LINE_W and mem_resp  input  1  physical-memory return.

Function
REQ-019 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RELEASE, plus a 1-bit last_grant register (0 = I, 1 = D).
REQ-020 IDLE: no request -> stay; only I requests -> SERVE_I; only D requests (read or write) -> SERVE_D; both -> grant the side not equal to last_grant, updating last_grant on the transition.
REQ-021 SERVE_I: mem_read=1, mem_write=0, mem_address=i_pmem_address, mem_wdata=0.
REQ-022 SERVE_D: mem_address=d_pmem_address, mem_wdata=d_pmem_wdata; d_pmem_write=1 -> mem_write=1, mem_read=0; else mem_read=1; write SHALL take precedence if both are asserted.
REQ-023 Command outputs SHALL be decoded combinationally from the state register; first command cycle is the cycle after the request is sampled in IDLE (1-cycle grant latency).
REQ-024 i_pmem_resp SHALL equal mem_resp AND state==SERVE_I; d_pmem_resp SHALL equal mem_resp AND state==SERVE_D; same cycle, no added latency; never both high.
REQ-025 i_pmem_rdata and d_pmem_rdata SHALL both be driven with mem_rdata unconditionally; only the resp strobes qualify them.
REQ-026 SERVE_x with mem_resp=1 -> RELEASE; without mem_resp -> stay, regardless of requester inputs (a dropped request SHALL NOT abort an in-flight memory transaction).
REQ-027 RELEASE: all mem_* commands 0, both resp 0, unconditionally -> IDLE, giving requesters one cycle to deassert.
REQ-028 Address and write data are not latched; requesters SHALL hold them stable from request until resp, and the arbiter SHALL pass them through live.
REQ-029 Back-to-back requests from the same side with the other side idle SHALL be served with a 2-cycle gap (RELEASE, IDLE) between transactions.
REQ-030 Starvation bound: with both sides continuously requesting, grants SHALL strictly alternate.

Reset
REQ-031 rst assertion SHALL, without waiting for clk, force state=IDLE and last_grant=0 (D wins the first tie), driving mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
REQ-032 Reset during SERVE_x SHALL abandon the transaction; a mem_resp arriving after reset release in IDLE SHALL be ignored (no resp strobe).

Verification
REQ-033 I-only read of 0x0000_0060, memory resp after 5 cycles -> mem_read high cycles 1-5, i_pmem_resp pulse on cycle 5 with rdata, d_pmem_resp never high.
REQ-034 D write-back to 0x0000_1000 with data 0xA5..A5 -> mem_write=1, mem_read=0, mem_wdata=0xA5..A5 until mem_resp; d_pmem_resp single pulse.
REQ-035 I and D requesting in the same cycle after reset -> D served first, then I; repeated simultaneous requests alternate D, I, D, I.
REQ-036 D asserts both read and write at 0x0000_2000 -> write issued, mem_read stays 0.
REQ-037 rst pulsed mid-SERVE_I, then late mem_resp -> outputs 0 immediately at rst, no i_pmem_resp after release, state IDLE.
REQ-038 I requester drops i_pmem_read mid-transaction -> mem_read held until mem_resp, then RELEASE and IDLE.
